// File: rtl/ftdi_sync_tx_pkg.sv
// Shared constants for the FTDI 245 synchronous-FIFO transmit path:
// strobe levels and default sizing.
package ftdi_sync_tx_pkg;

    localparam logic FTDI_ACTIVE = 1'b0;
    localparam logic FTDI_IDLE   = 1'b1;

    localparam int DEF_DEPTH    = 512;
    localparam int DEF_AW       = 9;
    localparam int DEF_CNT_BITS = 16;

endpackage

// File: rtl/ftdi_sync_tx_sync_fifo.sv
// Single-clock byte FIFO on an inferred block RAM with a registered read port.
// Full/empty come from the occupancy counter; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when a pop frees the slot at the same edge.
    always_comb begin
        do_pop  = pop && (level_q != '0);
        do_push = push && ((level_q != (AW+1)'(DEPTH)) || do_pop);
    end

    // No reset on the array or read register so the RAM maps onto block memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
        if (do_pop) begin
            rdata <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ftdi_sync_tx.sv
// Buffers the valid-only byte stream from packeter and writes it to an FT2232H
// in 245 synchronous FIFO mode, counting bytes lost while the FTDI stalls.
module ftdi_sync_tx
    import ftdi_sync_tx_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int CNT_BITS = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                overflow_clear,
    input  logic                ftdi_txe_n,
    output logic [7:0]          ftdi_data,
    output logic                ftdi_wr_n,
    output logic                ftdi_oe_n,
    output logic                ftdi_rd_n,
    output logic                ftdi_siwu_n,
    output logic [AW:0]         level,
    output logic                overflow,
    output logic [CNT_BITS-1:0] drop_count
);

    // Handshake: the held byte is transferred at an edge where ftdi_wr_n and
    // ftdi_txe_n are both sampled low; otherwise byte and strobe hold steady.

    logic                wr_n_q;
    logic [7:0]          data_q;
    logic                rd_pend;     // fifo_rdata holds a byte popped last edge
    logic [AW:0]         lvl_q;
    logic                ovf_q;
    logic [CNT_BITS-1:0] cnt_q;

    logic [7:0]          fifo_rdata;
    logic [AW:0]         fifo_level;

    logic stage_valid;
    logic accept;
    logic stage_free;
    logic stage_load;
    logic fifo_pop;
    logic full;
    logic push;
    logic drop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (fifo_pop),
        .wdata  (in_data),
        .rdata  (fifo_rdata),
        .level  (fifo_level)
    );

    // The read register acts as a prefetch slot so the stage can reload every
    // edge; level counts it as still buffered, and a stage load is the "pop".
    always_comb begin
        stage_valid = (wr_n_q == FTDI_ACTIVE);
        accept      = stage_valid && (ftdi_txe_n == FTDI_ACTIVE);
        stage_free  = !stage_valid || accept;
        stage_load  = stage_free && rd_pend;
        fifo_pop    = (fifo_level != '0) && (!rd_pend || stage_load);
        full        = (lvl_q == (AW+1)'(DEPTH));
        push        = in_valid && (!full || stage_load);
        drop        = in_valid && full && !stage_load;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_n_q  <= FTDI_IDLE;
            data_q  <= '0;
            rd_pend <= 1'b0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (fifo_pop) begin
                rd_pend <= 1'b1;
            end else if (stage_load) begin
                rd_pend <= 1'b0;
            end

            if (stage_free) begin
                wr_n_q <= rd_pend ? FTDI_ACTIVE : FTDI_IDLE;
                if (rd_pend) begin
                    data_q <= fifo_rdata;
                end
            end

            if (push && !stage_load) begin
                lvl_q <= lvl_q + 1'b1;
            end else if (!push && stage_load) begin
                lvl_q <= lvl_q - 1'b1;
            end

            // A clear in the same cycle as a drop wins; that drop goes uncounted.
            if (overflow_clear) begin
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign ftdi_data   = data_q;
    assign ftdi_wr_n   = wr_n_q;
    assign ftdi_oe_n   = FTDI_IDLE;
    assign ftdi_rd_n   = FTDI_IDLE;
    assign ftdi_siwu_n = FTDI_IDLE;
    assign level       = lvl_q;
    assign overflow    = ovf_q;
    assign drop_count  = cnt_q;

endmodule

// File: tb/tb_ftdi_sync_tx.sv
// Self-checking bench for ftdi_sync_tx (DEPTH=4, CNT_BITS=2): directed scenarios
// plus randomized traffic against a timestamped-queue reference model.
module tb_ftdi_sync_tx;

    localparam int DEPTH    = 4;
    localparam int AW       = 2;
    localparam int CNT_BITS = 2;

    logic                clk = 1'b0;
    logic                nreset;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                overflow_clear;
    logic                ftdi_txe_n;
    logic [7:0]          ftdi_data;
    logic                ftdi_wr_n;
    logic                ftdi_oe_n;
    logic                ftdi_rd_n;
    logic                ftdi_siwu_n;
    logic [AW:0]         level;
    logic                overflow;
    logic [CNT_BITS-1:0] drop_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        int         t;
    } ent_t;

    ent_t       m_q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovf;
    int         m_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ftdi_sync_tx #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .overflow_clear (overflow_clear),
        .ftdi_txe_n     (ftdi_txe_n),
        .ftdi_data      (ftdi_data),
        .ftdi_wr_n      (ftdi_wr_n),
        .ftdi_oe_n      (ftdi_oe_n),
        .ftdi_rd_n      (ftdi_rd_n),
        .ftdi_siwu_n    (ftdi_siwu_n),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    // ---------------- reference model ----------------
    // Bytes wait in a queue stamped with their push edge; the registered RAM
    // read means a byte reaches the output no sooner than two edges later.
    function automatic void model_step(input logic iv, input logic [7:0] d,
                                       input logic txe, input logic clr,
                                       input logic rst_n);
        logic acc;
        logic free;
        logic load;
        logic drp;
        int   lvl0;
        acc  = 1'b0;
        load = 1'b0;
        drp  = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
            m_cnt   = 0;
        end else begin
            lvl0 = m_q.size();
            acc  = m_valid && !txe;
            free = !m_valid || acc;
            if (acc) exp_q.push_back(m_data);
            if (free && lvl0 > 0) load = (m_q[0].t <= cyc - 2);
            if (load) begin
                m_data  = m_q[0].d;
                m_valid = 1'b1;
                void'(m_q.pop_front());
            end else if (free) begin
                m_valid = 1'b0;
            end
            if (iv) begin
                if (lvl0 < DEPTH || load) m_q.push_back('{d: d, t: cyc});
                else drp = 1'b1;
            end
            if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end else if (drp) begin
                m_ovf = 1'b1;
                if (m_cnt < (1 << CNT_BITS) - 1) m_cnt = m_cnt + 1;
            end
        end
        cyc = cyc + 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge: drive inputs, record any acceptance at the coming
    // edge, step the model on that edge, return at the next negedge.
    task automatic tick(input logic iv, input logic [7:0] d, input logic txe,
                        input logic clr, input logic rst_n);
        in_valid       = iv;
        in_data        = d;
        ftdi_txe_n     = txe;
        overflow_clear = clr;
        nreset         = rst_n;
        if (rst_n && ftdi_wr_n === 1'b0 && txe == 1'b0) act_q.push_back(ftdi_data);
        @(posedge clk);
        model_step(iv, d, txe, clr, rst_n);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_valid) && n < 50) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            n++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        if (n >= 50) begin
            bad++;
            $display("FAIL drain_timeout: model still busy after %0d cycles", n);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        act_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (ftdi_wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n: got %b want 1", ftdi_wr_n); end
        total++; if (ftdi_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", ftdi_data); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (overflow !== 1'b0 || drop_count !== 2'd0) begin
            bad++; $display("FAIL reset_drop: ovf=%b cnt=%0d want 0/0", overflow, drop_count);
        end
        total++; if ({ftdi_oe_n, ftdi_rd_n, ftdi_siwu_n} !== 3'b111) begin
            bad++; $display("FAIL tieoffs: got %b want 111", {ftdi_oe_n, ftdi_rd_n, ftdi_siwu_n});
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        clear_queues();
    endtask

    task automatic test_flow();
        logic [7:0] want [3];
        int low_cnt;
        int first_low;
        want = '{8'h01, 8'h02, 8'h03};
        low_cnt = 0;
        first_low = -1;
        clear_queues();
        for (int i = 0; i < 10; i++) begin
            tick(i < 3, 8'(i + 1), 1'b0, 1'b0, 1'b1);
            if (ftdi_wr_n === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
        end
        total++; if (first_low != 2) begin bad++; $display("FAIL flow_latency: first low after edge %0d want 2", first_low); end
        total++; if (low_cnt != 3) begin bad++; $display("FAIL flow_low_cycles: got %0d want 3", low_cnt); end
        total++; if (act_q.size() != 3) begin bad++; $display("FAIL flow_count: got %0d want 3", act_q.size()); end
        for (int i = 0; i < 3 && i < act_q.size(); i++) begin
            total++; if (act_q[i] !== want[i]) begin bad++; $display("FAIL flow_byte%0d: got %h want %h", i, act_q[i], want[i]); end
        end
        total++; if (level !== 3'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL flow_end: level=%0d ovf=%b want 0/0", level, overflow);
        end
    endtask

    task automatic test_stall();
        int unstable;
        unstable = 0;
        clear_queues();
        tick(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            if (ftdi_wr_n !== 1'b0 || ftdi_data !== 8'hA5) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold: %0d unstable cycles want 0", unstable); end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL stall_accepted: got %0d want 0", act_q.size()); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL stall_level: got %0d want 1", level); end
        drain();
        total++; if (act_q.size() != 2 || act_q[0] !== 8'hA5 || act_q[1] !== 8'h5A) begin
            bad++; $display("FAIL stall_order: got %0d bytes first=%h want A5,5A", act_q.size(),
                            act_q.size() > 0 ? act_q[0] : 8'hxx);
        end
    endtask

    task automatic test_fill_drop();
        logic [7:0] want [6];
        want = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h18};
        clear_queues();
        for (int i = 0; i < 7; i++) tick(1'b1, 8'(8'h11 + i), 1'b1, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level: got %0d want 4", level); end
        total++; if (drop_count !== 2'd2 || overflow !== 1'b1) begin
            bad++; $display("FAIL fill_drop: cnt=%0d ovf=%b want 2/1", drop_count, overflow);
        end
        total++; if (ftdi_wr_n !== 1'b0 || ftdi_data !== 8'h11) begin
            bad++; $display("FAIL fill_stage: wr_n=%b data=%h want 0/11", ftdi_wr_n, ftdi_data);
        end
        // Full, output accepted and a new byte arriving on the same edge.
        tick(1'b1, 8'h18, 1'b0, 1'b0, 1'b1);
        total++; if (level !== 3'd4 || drop_count !== 2'd2) begin
            bad++; $display("FAIL full_pop: level=%0d cnt=%0d want 4/2", level, drop_count);
        end
        drain();
        total++; if (act_q.size() != 6) begin bad++; $display("FAIL fill_count: got %0d want 6", act_q.size()); end
        for (int i = 0; i < 6 && i < act_q.size(); i++) begin
            total++; if (act_q[i] !== want[i]) begin bad++; $display("FAIL fill_byte%0d: got %h want %h", i, act_q[i], want[i]); end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        total++; if (overflow !== 1'b0 || drop_count !== 2'd0) begin
            bad++; $display("FAIL fill_clear: ovf=%b cnt=%0d want 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_clear_sat();
        clear_queues();
        for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b1);
        total++; if (drop_count !== 2'd3 || overflow !== 1'b1) begin
            bad++; $display("FAIL sat: cnt=%0d ovf=%b want 3/1", drop_count, overflow);
        end
        tick(1'b1, 8'h2A, 1'b1, 1'b1, 1'b1);
        total++; if (drop_count !== 2'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL clear_priority: cnt=%0d ovf=%b want 0/0", drop_count, overflow);
        end
        tick(1'b1, 8'h2B, 1'b1, 1'b0, 1'b1);
        total++; if (drop_count !== 2'd1 || overflow !== 1'b1) begin
            bad++; $display("FAIL drop_after_clear: cnt=%0d ovf=%b want 1/1", drop_count, overflow);
        end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL clear_keeps_data: level=%0d want 4", level); end
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drain();
        total++; if (act_q.size() != 5 || act_q[0] !== 8'h20 || act_q[4] !== 8'h24) begin
            bad++; $display("FAIL clear_order: got %0d bytes want 5 (20..24)", act_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b1);
        total++; if (level !== 3'd3 || ftdi_wr_n !== 1'b0) begin
            bad++; $display("FAIL mid_pre: level=%0d wr_n=%b want 3/0", level, ftdi_wr_n);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (ftdi_wr_n !== 1'b1 || ftdi_data !== 8'h00 || level !== 3'd0) begin
            bad++; $display("FAIL mid_reset: wr_n=%b data=%h level=%0d want 1/00/0", ftdi_wr_n, ftdi_data, level);
        end
        tick(1'b1, 8'h7E, 1'b0, 1'b0, 1'b1);
        drain();
        total++; if (act_q.size() != 1 || act_q[0] !== 8'h7E) begin
            bad++; $display("FAIL mid_after: got %0d bytes first=%h want only 7E", act_q.size(),
                            act_q.size() > 0 ? act_q[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        int stall_pct;
        int errs;
        logic iv;
        logic txe;
        logic clr;
        logic rst_n;
        errs = 0;
        stall_pct = 30;
        clear_queues();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) stall_pct = $urandom_range(0, 90);
            iv    = ($urandom_range(0, 99) < 60);
            txe   = ($urandom_range(0, 99) < stall_pct);
            clr   = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick(iv, 8'($urandom), txe, clr, rst_n);
            total++;
            if (ftdi_wr_n !== !m_valid || level !== 3'(m_q.size()) || overflow !== m_ovf ||
                drop_count !== 2'(m_cnt) || (m_valid && ftdi_data !== m_data)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_cycle%0d: wr_n=%b lvl=%0d ovf=%b cnt=%0d data=%h want %b/%0d/%b/%0d/%h",
                             i, ftdi_wr_n, level, overflow, drop_count, ftdi_data,
                             !m_valid, m_q.size(), m_ovf, m_cnt, m_data);
            end
        end
        drain();
        total++; if (act_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] a;
            logic [7:0] e;
            a = act_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (a !== e) begin bad++; $display("FAIL rand_byte: got %h want %h", a, e); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nreset         = 1'b0;
        in_valid       = 1'b0;
        in_data        = 8'h00;
        overflow_clear = 1'b0;
        ftdi_txe_n     = 1'b1;
        @(negedge clk);
        test_reset();
        test_flow();
        test_stall();
        test_fill_drop();
        test_clear_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
